// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw asynchronous input and accepts a change
// only after it has held steadily for STABLE_CYCLES+1 clock edges.
// Optional feature: define DEBOUNCE_BUSY_EN to get a registered `busy` output
// that is high while a candidate change is being qualified.
module input_debouncer #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic data_raw,
`ifdef DEBOUNCE_BUSY_EN
    output logic busy,
`endif
    output logic data_clean
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_d;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_ff <= {SYNC_STAGES{RESET_LEVEL}};
        else          sync_ff <= {sync_ff[SYNC_STAGES-2:0], data_raw};
    end

    // State, qualification counter and the clean output level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STABLE;
            cnt_q      <= '0;
            data_clean <= RESET_LEVEL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_clean <= clean_d;
        end
    end

    // Next state: any return to the old level restarts qualification from zero;
    // rejection is checked before acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = data_clean;
        case (state_q)
            STABLE: begin
                if (sync_q != data_clean) begin
                    state_d = QUALIFY;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            QUALIFY: begin
                if (sync_q == data_clean) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    clean_d = sync_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_BUSY_EN
    // Busy mirrors QUALIFY occupancy, updated on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy <= 1'b0;
        else          busy <= (state_d == QUALIFY);
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: two debouncers (STABLE_CYCLES=4/RESET_LEVEL=0 and
// STABLE_CYCLES=1/RESET_LEVEL=1) share one raw input; a window-based
// reference model feeds a scoreboard queue checked by a negedge monitor.
module tb_input_debouncer;

    localparam int SS = 2;

    logic clock;
    logic reset_n;
    logic data_raw;
    logic data_clean0, data_clean1;
`ifdef DEBOUNCE_BUSY_EN
    logic busy0, busy1;
`endif

    input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u_dut0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_raw   (data_raw),
`ifdef DEBOUNCE_BUSY_EN
        .busy       (busy0),
`endif
        .data_clean (data_clean0)
    );

    input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) u_dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_raw   (data_raw),
`ifdef DEBOUNCE_BUSY_EN
        .busy       (busy1),
`endif
        .data_clean (data_clean1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic c0;
        logic c1;
        logic b0;
        logic b1;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: raw samples, history of synchronised values,
    // number of edges since reset, expected clean and busy levels.
    logic [7:0]  m_raw   [2];
    logic [63:0] m_seen  [2];
    int          m_n     [2];
    logic        m_clean [2];
    logic        m_busy  [2];

    function automatic int sc_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic rl_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_raw[i]   = {8{rl_of(i)}};
            m_seen[i]  = '0;
            m_n[i]     = 0;
            m_clean[i] = rl_of(i);
            m_busy[i]  = 1'b0;
        end
    endtask

    // A change is accepted when the synchronised value has differed from the
    // clean level on each of the last STABLE_CYCLES+1 edges since reset.
    task automatic model_step(input int i, input logic v);
        logic fin;
        logic ok;
        fin       = m_raw[i][SS-1];
        m_raw[i]  = {m_raw[i][6:0], v};
        m_seen[i] = {m_seen[i][62:0], fin};
        m_n[i]++;
        if (m_n[i] >= sc_of(i) + 1) begin
            ok = 1'b1;
            for (int j = 0; j <= sc_of(i); j++)
                if (m_seen[i][j] == m_clean[i]) ok = 1'b0;
            if (ok) m_clean[i] = fin;
        end
        m_busy[i] = (fin != m_clean[i]);
    endtask

    // One clock: drive, wait for the edge, advance the model, push expectation.
    task automatic cycle(input logic v);
        exp_t e;
        data_raw = v;
        @(posedge clock);
        #1;
        model_step(0, v);
        model_step(1, v);
        e.c0 = m_clean[0];
        e.c1 = m_clean[1];
        e.b0 = m_busy[0];
        e.b1 = m_busy[1];
        sb_q.push_back(e);
    endtask

    // Reset between edges; outputs must change with no clock edge.
    task automatic do_reset(input logic v);
        @(negedge clock);
        #2;
        data_raw = v;
        reset_n  = 1'b0;
        #1;
        chk("reset_clean0", data_clean0, 1'b0);
        chk("reset_clean1", data_clean1, 1'b1);
`ifdef DEBOUNCE_BUSY_EN
        chk("reset_busy0", busy0, 1'b0);
        chk("reset_busy1", busy1, 1'b0);
`endif
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Hold v and report the edge (1-based) on which the chosen output reaches target.
    task automatic measure(input string name, input int inst, input logic v,
                           input logic target, input int exp_edge);
        int found;
        logic o;
        found = -1;
        for (int n = 1; n <= 30; n++) begin
            cycle(v);
            o = (inst == 0) ? data_clean0 : data_clean1;
            if (found < 0 && o == target) found = n;
        end
        chk_int(name, found, exp_edge);
    endtask

    // Monitor: every cycle the DUTs present a level; compare to the scoreboard.
    always @(negedge clock) begin : mon
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("clean0", data_clean0, e.c0);
            chk("clean1", data_clean1, e.c1);
`ifdef DEBOUNCE_BUSY_EN
            chk("busy0", busy0, e.b0);
            chk("busy1", busy1, e.b1);
`endif
        end
    end

    initial begin
        reset_n  = 1'b0;
        data_raw = 1'b1;
        model_reset();

        // Reset with raw high: rise accepted on edge 7 after release.
        do_reset(1'b1);
        measure("rise_after_reset", 0, 1'b1, 1'b1, 7);

        // Glitch of 3 cycles is rejected.
        do_reset(1'b0);
        repeat (3) cycle(1'b0);
        repeat (3) cycle(1'b1);
        repeat (10) cycle(1'b0);
        chk("glitch_clean0", data_clean0, 1'b0);

        // Clean step.
        measure("clean_step", 0, 1'b1, 1'b1, 7);

        // Bounce train, then hold high.
        do_reset(1'b0);
        repeat (3) cycle(1'b0);
        for (int k = 0; k < 20; k++) cycle((k % 4) < 2);
        chk("bounce_clean0", data_clean0, 1'b0);
        measure("bounce_settle", 0, 1'b1, 1'b1, 7);

        // Reset while cnt=2, then full restart.
        do_reset(1'b0);
        repeat (3) cycle(1'b0);
        repeat (4) cycle(1'b1);
        do_reset(1'b1);
        measure("restart_after_reset", 0, 1'b1, 1'b1, 7);

        // STABLE_CYCLES=1 instance: 1-cycle low glitch rejected, then fall on edge 4.
        cycle(1'b0);
        repeat (5) cycle(1'b1);
        chk("glitch_clean1", data_clean1, 1'b1);
        measure("fall_sc1", 1, 1'b0, 1'b0, 4);

        // Random runs with one random mid-run reset.
        for (int r = 0; r < 120; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if (r == 60) do_reset(1'($urandom_range(0, 1)));
            repeat (len) cycle(v);
        end

        repeat (2) @(negedge clock);
        #1;
        chk_int("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
